pc_sequencer: RTL

Parametrised program-counter sequencer for the core fetch stage, replacing the fixed-width reset-and-load PC register. It owns the architectural PC and computes the next PC itself from four sources: sequential step, stall hold, redirect (branch/jump/flush), and an optional return-address stack (RAS). It feeds instruction memory and the decode/execute pipeline, and reports misaligned redirects and RAS errors.

---
 rtl/pc_sequencer.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: owns the fetch PC and picks the next PC from step, stall, redirect and RAS.
// Optional return-address stack is enabled by defining PC_RAS_EN.
module pc_sequencer #(
   parameter int unsigned REG_DATA_WIDTH = 32,
   parameter logic [31:0] RESET_PC       = 32'hcc,
   parameter int unsigned PC_STEP        = 4,
   parameter int unsigned RAS_DEPTH      = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      stall_i,
   input  logic                      redirect_valid_i,
   input  logic [REG_DATA_WIDTH-1:0] redirect_pc_i,
   input  logic                      call_i,
   input  logic                      ret_i,
   output logic [REG_DATA_WIDTH-1:0] pc_o,
   output logic [REG_DATA_WIDTH-1:0] pc_plus_o,
   output logic                      pc_valid_o,
   output logic                      misalign_o,
   output logic                      ras_empty_o,
   output logic                      ras_full_o,
   output logic                      ras_err_o
);

   localparam int unsigned W      = REG_DATA_WIDTH;
   localparam int unsigned RAS_AW = $clog2(RAS_DEPTH);

   localparam logic [W-1:0] RESET_VAL = W'(RESET_PC);
   localparam logic [W-1:0] STEP_VAL  = W'(PC_STEP);
   localparam logic [W-1:0] STEP_MASK = W'(PC_STEP - 1);

   localparam logic [0:0] ST_RESET = 1'b0;
   localparam logic [0:0] ST_RUN   = 1'b1;

   logic [0:0]   state_q, state_d;
   logic [W-1:0] pc_q, pc_d;
   logic         misalign_q, misalign_d;
   logic         run;
   logic         ras_pop;
   logic [W-1:0] ras_top;

   assign run        = (state_q == ST_RUN);
   assign pc_o       = pc_q;
   assign pc_plus_o  = pc_q + STEP_VAL;
   assign pc_valid_o = run;
   assign misalign_o = misalign_q;

   // Priority: redirect (beats stall), stall, return, sequential step.
   always_comb begin
      state_d    = ST_RUN;
      pc_d       = pc_q;
      misalign_d = 1'b0;
      if (run) begin
         if (redirect_valid_i) begin
            pc_d       = redirect_pc_i & ~STEP_MASK;
            misalign_d = |(redirect_pc_i & STEP_MASK);
         end else if (!stall_i) begin
            if (ras_pop) begin
               pc_d = ras_top;
            end else begin
               pc_d = pc_plus_o;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_RESET;
         pc_q       <= RESET_VAL;
         misalign_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         misalign_q <= misalign_d;
      end
   end

`ifdef PC_RAS_EN
   localparam logic [RAS_AW:0]   CNT_FULL = (RAS_AW+1)'(RAS_DEPTH);
   localparam logic [RAS_AW-1:0] PTR_ONE  = RAS_AW'(1);
   localparam logic [RAS_AW:0]   CNT_ONE  = (RAS_AW+1)'(1);

   logic [W-1:0]      ras_mem [RAS_DEPTH];
   logic [RAS_AW-1:0] top_q, top_d, top_inc;
   logic [RAS_AW:0]   cnt_q, cnt_d;
   logic              ras_err_q, ras_err_d;
   logic              ras_push;
   logic              ret_take;

   assign ras_push  = run && redirect_valid_i && call_i;
   assign ret_take  = run && !redirect_valid_i && !stall_i && ret_i;
   assign ras_pop   = ret_take && (cnt_q != '0);
   assign ras_err_d = ret_take && (cnt_q == '0);
   assign top_inc   = top_q + PTR_ONE;
   assign ras_top   = ras_mem[top_q];

   // A push into a full stack wraps onto the oldest slot; the count saturates.
   always_comb begin
      top_d = top_q;
      cnt_d = cnt_q;
      if (ras_push) begin
         top_d = top_inc;
         if (cnt_q != CNT_FULL) begin
            cnt_d = cnt_q + CNT_ONE;
         end
      end else if (ras_pop) begin
         top_d = top_q - PTR_ONE;
         cnt_d = cnt_q - CNT_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (ras_push) begin
         ras_mem[top_inc] <= pc_plus_o;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         top_q     <= '0;
         cnt_q     <= '0;
         ras_err_q <= 1'b0;
      end else begin
         top_q     <= top_d;
         cnt_q     <= cnt_d;
         ras_err_q <= ras_err_d;
      end
   end

   assign ras_empty_o = (cnt_q == '0);
   assign ras_full_o  = (cnt_q == CNT_FULL);
   assign ras_err_o   = ras_err_q;
`else
   logic [RAS_AW:0] unused_ras;

   assign unused_ras  = {{RAS_AW{1'b0}}, call_i ^ ret_i};
   assign ras_pop     = 1'b0;
   assign ras_top     = '0;
   assign ras_empty_o = 1'b1;
   assign ras_full_o  = 1'b0;
   assign ras_err_o   = 1'b0;
`endif

endmodule
